// File: rtl/wb_cmd_master.sv
// Valid/ready command stream to Wishbone B4 classic single read/write cycles, with bounded rty retry.
// Optional ack timeout is built only when WB_MASTER_TIMEOUT_EN is defined.
module wb_cmd_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_adr,
  input  logic [DATA_WIDTH-1:0] cmd_wdat,
  input  logic [3:0]            cmd_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdat,
  output logic [1:0]            rsp_status,
  output logic [ADDR_WIDTH-1:0] wb_adr,
  output logic [DATA_WIDTH-1:0] wb_wdat,
  output logic [3:0]            wb_sel,
  output logic                  wb_we,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic [2:0]            wb_cti,
  output logic [1:0]            wb_bte,
  input  logic [DATA_WIDTH-1:0] wb_rdat,
  input  logic                  wb_ack,
  input  logic                  wb_err,
  input  logic                  wb_rty
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  if (MAX_RETRY < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("wb_cmd_master: MAX_RETRY and TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_e;

  state_e                state_q, state_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [3:0]            sel_q, sel_d;
  logic                  we_q, we_d;
  logic                  cyc_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic [1:0]            status_q, status_d;
  logic                  tmo_hit;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Cleared whenever outside BUS, so every entry to BUS starts from zero.
  always_comb begin
    tmo_d = '0;
    if (state_q == BUS)
      tmo_d = (tmo_q == TW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + TW'(1);
  end

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) tmo_q <= '0;
    else           tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    sel_d    = sel_q;
    we_d     = we_q;
    rdat_d   = rdat_q;
    status_d = status_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        adr_d   = cmd_adr;
        wdat_d  = cmd_wdat;
        sel_d   = cmd_sel;
        we_d    = cmd_we;
        retry_d = '0;
        if (cmd_we) rdat_d = '0;
        state_d = BUS;
      end
      BUS: begin
        if (wb_err) begin
          status_d = 2'b01;
          state_d  = RESP;
        end else if (wb_ack) begin
          if (!we_q) rdat_d = wb_rdat;
          status_d = 2'b00;
          state_d  = RESP;
        end else if (wb_rty) begin
          if (retry_q == RW'(MAX_RETRY)) begin
            status_d = 2'b10;
            state_d  = RESP;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = BACKOFF;
          end
        end else if (tmo_hit) begin
          status_d = 2'b11;
          state_d  = RESP;
        end
      end
      BACKOFF: state_d = BUS;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q     <= IDLE;
      retry_q     <= '0;
      adr_q       <= '0;
      wdat_q      <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdat_q      <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      cyc_q       <= (state_d == BUS);
      rsp_valid_q <= (state_d == RESP);
      rdat_q      <= rdat_d;
      status_q    <= status_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE) && wb_rst_n;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdat   = rdat_q;
  assign rsp_status = status_q;
  assign wb_adr     = adr_q;
  assign wb_wdat    = wdat_q;
  assign wb_sel     = sel_q;
  assign wb_we      = we_q;
  assign wb_cyc     = cyc_q;
  assign wb_stb     = cyc_q;
  assign wb_cti     = '0;
  assign wb_bte     = '0;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed and random commands against a slave script and reference model.
module tb_wb_cmd_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MR = 3;
  localparam int TC = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [DW-1:0] cmd_wdat;
  logic [3:0]    cmd_sel;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdat;
  logic [1:0]    rsp_status;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_wdat, wb_rdat;
  logic [3:0]    wb_sel;
  logic          wb_we, wb_cyc, wb_stb, wb_ack, wb_err, wb_rty;
  logic [2:0]    wb_cti;
  logic [1:0]    wb_bte;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model_rdat;

  always #5 clk = ~clk;

  wb_cmd_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_RETRY(MR), .TIMEOUT_CYCLES(TC)
  ) dut (
    .wb_clk(clk), .wb_rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_wdat(cmd_wdat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdat(rsp_rdat), .rsp_status(rsp_status),
    .wb_adr(wb_adr), .wb_wdat(wb_wdat), .wb_sel(wb_sel), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_cti(wb_cti), .wb_bte(wb_bte),
    .wb_rdat(wb_rdat), .wb_ack(wb_ack), .wb_err(wb_err), .wb_rty(wb_rty)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // term: 0 ack, 1 err, 2 ack+err+rty together, 3 silent slave (timeout build only)
  task automatic run_cmd(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] wdat,
                         input logic [3:0] sel, input int waits, input int nrty, input int term,
                         input logic [DW-1:0] rd, input int hold);
    int phases, exp_stb, exp_lat, stb_cnt, gap_cnt, lat, ph, idx;
    logic [1:0] exp_st;
    bit hold_bad, resp_bad;
    if (nrty > MR) begin
      phases = MR + 1;
      exp_st = 2'b10;
    end else begin
      phases = nrty + 1;
      exp_st = (term == 0) ? 2'b00 : (term == 3) ? 2'b11 : 2'b01;
    end
    exp_stb = (term == 3 && nrty <= MR) ? nrty * (waits + 1) + TC : phases * (waits + 1);
    exp_lat = exp_stb + (phases - 1) + 1;
    if (we) model_rdat = '0;
    else if (exp_st == 2'b00) model_rdat = rd;

    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_wdat = wdat; cmd_sel = sel;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = $urandom; cmd_wdat = $urandom; cmd_sel = 4'($urandom);
    lat = 1; stb_cnt = 0; gap_cnt = 0; ph = 0; idx = 0; hold_bad = 1'b0;
    while (!rsp_valid && lat < 3000) begin
      wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0; wb_rdat = $urandom;
      rsp_ready = 1'($urandom);
      if (cmd_ready !== 1'b0) hold_bad = 1'b1;
      if (wb_cyc === 1'b1) begin
        stb_cnt++;
        if (wb_stb !== 1'b1 || wb_adr !== adr || wb_wdat !== wdat || wb_sel !== sel || wb_we !== we)
          hold_bad = 1'b1;
        if (idx == waits && !(ph >= nrty && term == 3)) begin
          if (ph < nrty) wb_rty = 1'b1;
          else if (term == 0) begin wb_ack = 1'b1; wb_rdat = rd; end
          else if (term == 1) wb_err = 1'b1;
          else begin wb_ack = 1'b1; wb_err = 1'b1; wb_rty = 1'b1; wb_rdat = rd; end
          ph++;
          idx = 0;
        end else idx++;
      end else begin
        gap_cnt++;
        if (wb_stb !== 1'b0 || wb_adr !== adr || wb_wdat !== wdat) hold_bad = 1'b1;
        idx = 0;
      end
      @(negedge clk);
      lat++;
    end
    rsp_ready = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
    chk("latency", lat, exp_lat);
    chk("stb_cycles", stb_cnt, exp_stb);
    chk("backoff_gaps", gap_cnt, phases - 1);
    chk("bus_hold", hold_bad, 1'b0);
    chk("cyc_dropped", {wb_cyc, wb_stb}, 2'b00);
    chk("status", rsp_status, exp_st);
    chk("rdat", rsp_rdat, model_rdat);
    resp_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_status !== exp_st || rsp_rdat !== model_rdat)
        resp_bad = 1'b1;
    end
    chk("resp_stable", resp_bad, 1'b0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("resp_done", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    bit any_rsp;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_wdat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wb_rdat = '0; wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
    model_rdat = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_bus", {wb_cyc, wb_stb, wb_we, wb_adr, wb_wdat, wb_sel}, '0);
    chk("rst_rsp", {rsp_valid, rsp_rdat, rsp_status}, '0);
    chk("cti_bte", {wb_cti, wb_bte}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0, 0);
    run_cmd(1'b0, 32'h2004, 32'h0, 4'hF, 3, 0, 0, 32'h12345678, 5);
    run_cmd(1'b0, 32'h3000, 32'h0, 4'h3, 0, 4, 0, 32'hAAAA5555, 1);
    run_cmd(1'b0, 32'h3004, 32'h0, 4'hF, 1, 0, 2, 32'h0BADF00D, 2);
    run_cmd(1'b0, 32'h3008, 32'h0, 4'hF, 0, 2, 0, 32'hCAFE0001, 0);
`ifdef WB_MASTER_TIMEOUT_EN
    run_cmd(1'b0, 32'h4000, 32'h0, 4'hF, 0, 0, 3, 32'h0, 1);
    run_cmd(1'b1, 32'h4004, 32'h11, 4'h1, 0, 2, 3, 32'h0, 0);
`endif

    for (int n = 0; n < 24; n++) begin
      int t;
`ifdef WB_MASTER_TIMEOUT_EN
      t = $urandom_range(0, 3);
`else
      t = $urandom_range(0, 2);
`endif
      run_cmd(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 4), t, $urandom, $urandom_range(0, 3));
    end

    // Reset during a bus wait with a silent slave
    chk("pre_rst_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h5000; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
    repeat (TC - 3) @(negedge clk);
`else
    repeat (1000) @(negedge clk);
`endif
    chk("stb_waiting", {wb_cyc, wb_stb, rsp_valid}, 3'b110);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_bus", {wb_cyc, wb_stb, rsp_valid, cmd_ready}, 4'b0000);
    chk("rst_mid_rsp", {rsp_rdat, rsp_status}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    model_rdat = '0;
    any_rsp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || wb_cyc !== 1'b0) any_rsp = 1'b1;
    end
    chk("no_rsp_after_rst", any_rsp, 1'b0);
    run_cmd(1'b0, 32'h6000, 32'h0, 4'hF, 0, 1, 0, 32'h600DD00D, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

- Converts a simple valid/ready command stream into Wishbone B4 classic single-read/single-write bus cycles, and returns a response stream carrying read data and a completion status.
- Sits directly upstream of the Wishbone bus: its bus-side ports connect one-to-one to the `master` modport signals of the Wishbone interface.
- Adds bounded retry on `wb_rty` and an optional ack timeout.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width; `wb_sel` is fixed at 4 bits.
- `MAX_RETRY`, 3, number of `wb_rty` retries before failing; minimum 1.
- `TIMEOUT_CYCLES`, 255, cycles a strobe may wait for termination; only used with `WB_MASTER_TIMEOUT_EN`.

Ports:
- `wb_clk` in 1: the single clock; all logic is on its rising edge.
- `wb_rst_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_we` in 1: 1 = write, 0 = read.
- `cmd_adr` in ADDR_WIDTH: command address.
- `cmd_wdat` in DATA_WIDTH: write data.
- `cmd_sel` in 4: byte selects.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_rdat` out DATA_WIDTH: captured read data; 0 for writes.
- `rsp_status` out 2: 00 OK, 01 ERR, 10 RETRY_EXHAUSTED, 11 TIMEOUT.
- `wb_adr`, `wb_wdat`, `wb_sel`, `wb_we`, `wb_cyc`, `wb_stb`, `wb_cti`, `wb_bte` out: bus outputs, widths per the interface; `wb_cti` and `wb_bte` are tied 0.
- `wb_rdat`, `wb_ack`, `wb_err`, `wb_rty` in: bus inputs.

## Operation
- FSM states: IDLE, BUS, BACKOFF, RESP.
- IDLE:
  - `cmd_ready` = 1.
  - On `cmd_valid`, register `cmd_we`, `cmd_adr`, `cmd_wdat` and `cmd_sel` onto the bus output registers, clear the retry and timeout counters, and go to BUS.
- BUS: `wb_cyc` = `wb_stb` = 1. Termination is sampled each edge with priority err > ack > rty:
  - `wb_err`: go to RESP with status 01.
  - `wb_ack`: for reads, capture `wb_rdat` into `rsp_rdat`; go to RESP with status 00.
  - `wb_rty` with retry count < MAX_RETRY: increment the count and go to BACKOFF.
  - `wb_rty` with retry count == MAX_RETRY: go to RESP with status 10.
- BACKOFF:
  - `wb_cyc` = `wb_stb` = 0 for exactly one cycle, bus address and data held, then return to BUS.
  - The timeout counter is cleared on entry to BUS.
- RESP:
  - `rsp_valid` = 1; `rsp_rdat` and `rsp_status` are stable.
  - On `rsp_ready`, go to IDLE.
- Bus outputs: `wb_adr`, `wb_wdat`, `wb_sel` and `wb_we` hold their last values outside BUS; only `wb_cyc`/`wb_stb` qualify them.
- Retry counter is `$clog2(MAX_RETRY+1)` bits and never wraps. The timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits and saturates.
- Reset: every output register is 0 (`wb_cyc`, `wb_stb`, `wb_we`, `wb_adr`, `wb_wdat`, `wb_sel`, `rsp_valid`, `rsp_rdat`, `rsp_status`), `cmd_ready` is 0 while reset is asserted, and the state is IDLE.
  - A reset asserted mid-cycle drops `wb_cyc`/`wb_stb` at that edge.
  - The pending command is discarded and no response is produced.

## Timing
- The command is accepted at edge N; `wb_cyc`/`wb_stb` are high from cycle N+1.
- If `wb_ack` is sampled at edge M, `wb_cyc`/`wb_stb` are low and `rsp_valid` is high from cycle M+1.
- Minimum latency, accept to `rsp_valid`, is 2 cycles (zero-wait-state slave).
- Each retry costs 1 BACKOFF cycle plus the slave's wait.
- `cmd_ready` is low from N+1 until the cycle after the `rsp_valid && rsp_ready` edge; back-to-back throughput is 1 command per 3 cycles minimum.
- Ack, err and rty asserted together: err wins; `rsp_rdat` is not updated.
- `rsp_ready` held high in IDLE/BUS is ignored.
- `cmd_valid` while not ready is ignored. The command must be held by the source until accepted.

## Configuration
- Macro `WB_MASTER_TIMEOUT_EN`.
- Defined: in BUS, the timeout counter increments each cycle without a termination. When it reaches TIMEOUT_CYCLES, that edge drops `wb_cyc`/`wb_stb` and the FSM enters RESP with status 11. A termination on the same edge takes priority over the timeout.
- Undefined: no timeout counter is built, BUS waits indefinitely, and status 11 is never produced.

## Test plan
- Write 0x1000←0xDEADBEEF, sel 0xF, slave acks 1st strobe cycle → `wb_cyc` high exactly 1 cycle with `wb_we`=1; `rsp_valid` 2 cycles after accept; status 00; `rsp_rdat`=0.
- Read 0x2004, slave waits 3 cycles then acks with 0x12345678 → `wb_stb` high 4 cycles; `rsp_rdat`=0x12345678; status 00.
- MAX_RETRY=3, slave answers `wb_rty` 4 times → 3 one-cycle BACKOFF gaps, 4 strobe phases, status 10.
- Slave asserts ack and err together on a read → status 01; `rsp_rdat` keeps its previous value.
- With `WB_MASTER_TIMEOUT_EN`, TIMEOUT_CYCLES=8, slave silent → `wb_stb` drops after 8 cycles, status 11. Without the macro → `wb_stb` is still high after 1000 cycles.
- `wb_rst_n` pulled low during a BUS wait, and `rsp_ready` held low in RESP across 5 cycles → reset clears `wb_cyc`/`wb_stb`/`rsp_valid` next edge with no response. In RESP, outputs stay stable and `cmd_ready` stays 0 until `rsp_ready`.
